// File: rtl/signed_accumulator_unit.sv
// Signed 8-bit accumulator wrapped around an add/subtract datapath, with
// sticky overflow, accepted-operation counter and valid/ready result handshake.
module signed_accumulator_unit #(
   parameter int SATURATE = 0,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       operand,
   input  logic             opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       acc,
   output logic             overflow,
   output logic             overflow_sticky,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t     state;
   logic [7:0] op_q;
   logic       opc_q;
   logic [7:0] b_eff;
   logic [7:0] raw;
   logic [7:0] result;
   logic       ovf;

   // Subtraction reuses the adder: invert b and inject the +1 as carry-in.
   always_comb begin
      b_eff  = opc_q ? ~op_q : op_q;
      raw    = acc + b_eff + {7'b0, opc_q};
      if (opc_q)
         ovf = (acc[7] != op_q[7]) && (raw[7] != acc[7]);
      else
         ovf = (acc[7] == op_q[7]) && (raw[7] != acc[7]);
      result = raw;
      if ((SATURATE != 0) && ovf)
         result = acc[7] ? 8'h80 : 8'h7F;
   end

   assign in_ready = (state == IDLE) && !clear;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         acc             <= '0;
         overflow        <= 1'b0;
         overflow_sticky <= 1'b0;
         op_count        <= '0;
         out_valid       <= 1'b0;
         op_q            <= '0;
         opc_q           <= 1'b0;
      end else if (clear) begin
         state           <= IDLE;
         acc             <= '0;
         overflow        <= 1'b0;
         overflow_sticky <= 1'b0;
         op_count        <= '0;
         out_valid       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  op_q     <= operand;
                  opc_q    <= opcode;
                  op_count <= op_count + CNT_W'(1);
                  state    <= EXEC;
               end
            end
            EXEC: begin
               acc             <= result;
               overflow        <= ovf;
               overflow_sticky <= overflow_sticky | ovf;
               out_valid       <= 1'b1;
               state           <= RESP;
            end
            RESP: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
